fetch_line_unpacker: RTL and testbench

//  Writer side of the instruction fetch queue. Accepts one cache line per handshake from the
//  I-cache response path and emits one {pc, instr} packet per cycle into the queue. It honours
//  the queue's full flag and discards in-flight work on a redirect flush.

---
 rtl/fetch_line_unpacker_pkg.sv | 19 +
 rtl/fetch_line_unpacker_if.sv | 31 +++
 rtl/fetch_line_unpacker.sv | 81 ++++++++
 tb/tb_fetch_line_unpacker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_line_unpacker_pkg.sv
// Shared types and default widths for the fetch-line unpacker slice.
package fetch_line_unpacker_pkg;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_ADDR_W  = 32;

  // One fetch queue entry: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    UNPK_IDLE,
    UNPK_EMIT
  } unpacker_state_t;

endpackage

// File: rtl/fetch_line_unpacker_if.sv
// I-cache response side plus fetch queue write side of the unpacker.
// The slave modport is the unpacker; the master modport is the cache/queue environment.
interface fetch_line_unpacker_if
  import fetch_line_unpacker_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W
);

  logic                      line_valid;
  logic                      line_ready;
  logic [LINE_W-1:0]         line_data;
  logic [ADDR_W-1:0]         line_pc;
  logic                      flush;
  logic                      q_full;
  logic                      enqueue;
  logic [ADDR_W+INSTR_W-1:0] wdata;
  logic                      busy;

  modport slave (
    input  line_valid, line_data, line_pc, flush, q_full,
    output line_ready, enqueue, wdata, busy
  );

  modport master (
    output line_valid, line_data, line_pc, flush, q_full,
    input  line_ready, enqueue, wdata, busy
  );

endinterface

// File: rtl/fetch_line_unpacker.sv
// Writer side of the instruction fetch queue: takes one cache line per handshake
// and pushes one {pc, instr} packet per cycle, honouring queue full and redirect flush.
module fetch_line_unpacker
  import fetch_line_unpacker_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_line_unpacker_if.slave  bus
);

  localparam int WORDS = LINE_W / INSTR_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF   = $clog2(INSTR_W / 8);

  // Clears the word index and byte offset bits so base_q points at the line start.
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (OFF + IDX_W);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);

  unpacker_state_t   state_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;

  logic              emit;
  logic              last;
  logic              accept;
  logic [IDX_W-1:0]  start_idx;

  assign emit      = (state_q == UNPK_EMIT);
  assign last      = (idx_q == LAST_IDX);
  assign start_idx = bus.line_pc[OFF+IDX_W-1:OFF];

  // Handshake outputs are combinational so a new line can overlap the last word.
  assign bus.enqueue    = rst_n & emit & ~bus.q_full & ~bus.flush;
  assign bus.line_ready = rst_n & ~bus.flush & (~emit | (last & ~bus.q_full));
  assign bus.busy       = rst_n & emit;
  assign accept         = bus.line_valid & bus.line_ready;

  assign bus.wdata = {base_q | (ADDR_W'(idx_q) << OFF),
                      line_q[idx_q*INSTR_W +: INSTR_W]};

  // Line capture, word stepping and flush/reset discard in one state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNPK_IDLE;
      idx_q   <= '0;
    end else if (bus.flush) begin
      state_q <= UNPK_IDLE;
    end else begin
      case (state_q)
        UNPK_IDLE: begin
          if (accept) begin
            line_q  <= bus.line_data;
            base_q  <= bus.line_pc & BASE_MASK;
            idx_q   <= start_idx;
            state_q <= UNPK_EMIT;
          end
        end
        UNPK_EMIT: begin
          if (accept) begin
            line_q  <= bus.line_data;
            base_q  <= bus.line_pc & BASE_MASK;
            idx_q   <= start_idx;
          end else if (bus.enqueue) begin
            if (last) begin
              state_q <= UNPK_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= UNPK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_unpacker.sv
// Directed self-checking bench for fetch_line_unpacker.
module tb_fetch_line_unpacker;
  import fetch_line_unpacker_pkg::*;

  localparam int LINE_W  = 256;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int WORDS   = LINE_W / INSTR_W;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [63:0] got[$];

  fetch_line_unpacker_if #(.LINE_W(LINE_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_if ();

  fetch_line_unpacker #(.LINE_W(LINE_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: record every packet pushed, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && u_if.enqueue === 1'b1) got.push_back(u_if.wdata);
  end

  function automatic logic [LINE_W-1:0] mkLine(input logic [31:0] w0);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*INSTR_W +: INSTR_W] = w0 + 32'(i);
    return l;
  endfunction

  function automatic logic [63:0] pkt(input logic [31:0] pc, input logic [31:0] instr);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] w0,
                               input logic fl, input logic full);
    u_if.line_valid = valid;
    u_if.line_pc    = pc;
    u_if.line_data  = mkLine(w0);
    u_if.flush      = fl;
    u_if.q_full     = full;
  endtask

  task automatic checkOutput(input string tag, input logic enq, input logic rdy, input logic bsy,
                             input logic [31:0] pc, input logic [31:0] instr);
    #2;
    chk({tag, ".enqueue"}, 64'(u_if.enqueue), 64'(enq));
    chk({tag, ".line_ready"}, 64'(u_if.line_ready), 64'(rdy));
    chk({tag, ".busy"}, 64'(u_if.busy), 64'(bsy));
    if (enq) chk({tag, ".wdata"}, u_if.wdata, pkt(pc, instr));
  endtask

  // Present words first..first+n-1 of a line at base 'pc' whose word i is w0+i.
  task automatic runWords(input string tag, input int first, input int n,
                          input logic [31:0] pc, input logic [31:0] w0);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = first + k;
      checkOutput(tag, 1'b1, (idx == WORDS - 1), 1'b1, pc + 32'(4 * idx), w0 + 32'(idx));
      nextCycle();
    end
  endtask

  initial begin
    int s0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    checkOutput("post_reset", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] test 1: full line from 0x1000");
    applyStimulus(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    checkOutput("t1_accept", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runWords("t1", 0, 8, 32'h1000, 32'hA0);
    checkOutput("t1_idle", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] test 2: mid-line start 0x1014");
    applyStimulus(1'b1, 32'h1014, 32'hA0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    s0 = got.size();
    runWords("t2", 5, 3, 32'h1000, 32'hA0);
    checkOutput("t2_idle", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t2_count", 64'(got.size() - s0), 64'd3);

    $display("[TB] test 3: queue full on word 2");
    applyStimulus(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    s0 = got.size();
    runWords("t3a", 0, 2, 32'h1000, 32'hA0);
    for (int k = 0; k < 3; k++) begin
      u_if.q_full = 1'b1;
      checkOutput("t3_full", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      nextCycle();
    end
    u_if.q_full = 1'b0;
    runWords("t3b", 2, 6, 32'h1000, 32'hA0);
    chk("t3_count", 64'(got.size() - s0), 64'd8);
    for (int k = 0; k < 8; k++)
      chk("t3_order", got[s0 + k], pkt(32'h1000 + 32'(4 * k), 32'hA0 + 32'(k)));

    $display("[TB] test 4: back-to-back lines");
    applyStimulus(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runWords("t4a", 0, 7, 32'h1000, 32'hA0);
    applyStimulus(1'b1, 32'h1020, 32'hB0, 1'b0, 1'b0);
    checkOutput("t4_overlap", 1'b1, 1'b1, 1'b1, 32'h101C, 32'hA7);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runWords("t4b", 0, 8, 32'h1020, 32'hB0);
    checkOutput("t4_idle", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] test 5: flush on word 3");
    applyStimulus(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runWords("t5a", 0, 3, 32'h1000, 32'hA0);
    s0 = got.size();
    u_if.flush = 1'b1;
    checkOutput("t5_flush", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    nextCycle();
    u_if.flush = 1'b0;
    checkOutput("t5_after", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t5_count", 64'(got.size() - s0), 64'd0);
    applyStimulus(1'b1, 32'h2000, 32'hC0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runWords("t5b", 0, 8, 32'h2000, 32'hC0);
    checkOutput("t5_idle", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] test 6: reset mid-line");
    applyStimulus(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    s0 = got.size();
    runWords("t6a", 0, 3, 32'h1000, 32'hA0);
    rst_n = 1'b0;
    checkOutput("t6_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    checkOutput("t6_release", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("t6_idle", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t6_count", 64'(got.size() - s0), 64'd3);
    chk("t6_lastpkt", got[got.size() - 1], pkt(32'h1008, 32'hA2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
